// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: defaults, FSM encoding
// and small PC arithmetic helpers.
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

    // Fetch controller states.
    //   IF_IDLE  : one quiet cycle after reset before the first request
    //   IF_FETCH : request outstanding at pc
    //   IF_HOLD  : response captured in the skid register while ID is stalled
    //   IF_DROP  : redirected while a request was in flight; wait out the stale response
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DROP  = 2'd3
    } if_state_t;

    // Word addresses only: the two low bits are always zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential next PC, wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_ifid.sv
// IF/ID pipeline register. Clear inserts a bubble (NOP, valid=0) and keeps
// the link value; clear wins over the write enable.
module ifid_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        clear,
    input  logic [31:0] d_inst,
    input  logic [31:0] d_pc4,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        valid
);

    // Register update: reset, then bubble, then load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst  <= NOP_INST;
            pc4   <= 32'd0;
            valid <= 1'b0;
        end else if (clear) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (we) begin
            inst  <= d_inst;
            pc4   <= d_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/ready instruction-memory
// handshake and feeds the IF/ID register.
//
// Handshake: imem_req/imem_addr are asserted by this stage and held constant
// until the cycle in which imem_ready=1; the word on imem_rdata is taken in
// that same cycle. imem_ready with imem_req=0 is ignored. A request is never
// withdrawn once raised, so a redirect during a wait drains through IF_DROP.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        IFID_Write,
    input  logic        IFID_Clear,
    input  logic        PC_Br,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output if_state_t   fsm_state
);

    if_state_t   state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] skid, skid_n;
    logic [31:0] drop_addr, drop_addr_n;
    logic        stall;
    logic        load;
    logic        bubble;
    logic [31:0] load_inst;
    logic        ifid_clear;

    assign stall     = !PC_Write || !IFID_Write;
    assign fsm_state = state;

    // State, PC, skid and stale-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IF_IDLE;
            pc        <= word_align(RESET_PC);
            skid      <= NOP_INST;
            drop_addr <= 32'd0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            skid      <= skid_n;
            drop_addr <= drop_addr_n;
        end
    end

    // Next-state, PC update, memory request and IF/ID control.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        skid_n      = skid;
        drop_addr_n = drop_addr;
        load        = 1'b0;
        bubble      = 1'b0;
        load_inst   = skid;
        imem_req    = 1'b0;
        imem_addr   = pc;

        case (state)
            IF_IDLE: begin
                state_n = IF_FETCH;
                if (PC_Br) begin
                    pc_n = word_align(br_target);
                end
            end

            IF_FETCH: begin
                imem_req = 1'b1;
                if (PC_Br) begin
                    pc_n = word_align(br_target);
                    if (!imem_ready) begin
                        // Request still in flight: remember its address and drain it.
                        drop_addr_n = pc;
                        state_n     = IF_DROP;
                    end
                end else if (imem_ready) begin
                    if (!stall) begin
                        load      = 1'b1;
                        load_inst = imem_rdata;
                        pc_n      = pc_plus4(pc);
                    end else begin
                        // ID cannot accept: park the word and stop requesting.
                        skid_n  = imem_rdata;
                        state_n = IF_HOLD;
                    end
                end else begin
                    bubble = IFID_Write;
                end
            end

            IF_HOLD: begin
                if (PC_Br) begin
                    pc_n    = word_align(br_target);
                    state_n = IF_FETCH;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_inst = skid;
                    pc_n      = pc_plus4(pc);
                    state_n   = IF_FETCH;
                end
            end

            IF_DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr;
                bubble    = IFID_Write;
                if (PC_Br) begin
                    pc_n = word_align(br_target);
                end
                if (imem_ready) begin
                    state_n = IF_FETCH;
                end
            end

            default: begin
                state_n = IF_IDLE;
            end
        endcase
    end

    // A redirect always squashes whatever IF/ID would have captured this edge.
    assign ifid_clear = IFID_Clear || PC_Br || bubble;

    ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (load),
        .clear  (ifid_clear),
        .d_inst (load_inst),
        .d_pc4  (pc_plus4(pc)),
        .inst   (ifid_inst),
        .pc4    (ifid_pc4),
        .valid  (ifid_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The instruction memory returns its address as
// data, so every expected instruction equals the fetch address.
module tb_if_stage;
    import if_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic        PC_Write, IFID_Write, IFID_Clear, PC_Br;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_inst, ifid_pc4;
    logic        ifid_valid;
    if_state_t   fsm_state;

    assign imem_rdata = imem_addr;

    if_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PC_Write   (PC_Write),
        .IFID_Write (IFID_Write),
        .IFID_Clear (IFID_Clear),
        .PC_Br      (PC_Br),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_inst  (ifid_inst),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .fsm_state  (fsm_state)
    );

    // ---------------- vector record ----------------
    typedef struct {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_clear;
        logic        pc_br;
        logic [31:0] target;
        logic        ready;
        logic        exp_req;   // before the edge
        logic [31:0] exp_addr;  // before the edge
        logic [31:0] exp_inst;  // after the edge
        logic [31:0] exp_pc4;   // after the edge
        logic        exp_valid; // after the edge
    } vec_t;

    function automatic vec_t mk(input logic pw, input logic iw, input logic cl,
                                input logic br, input logic [31:0] tgt, input logic rdy,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic [31:0] einst, input logic [31:0] epc4,
                                input logic evalid);
        vec_t v;
        v.pc_write = pw;  v.ifid_write = iw; v.ifid_clear = cl; v.pc_br = br;
        v.target = tgt;   v.ready = rdy;
        v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_inst = einst; v.exp_pc4 = epc4; v.exp_valid = evalid;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},   32'(imem_req),   32'd0);
        check({tag, ".addr"},  imem_addr,       32'h0000_3000);
        check({tag, ".inst"},  ifid_inst,       32'h0000_0000);
        check({tag, ".pc4"},   ifid_pc4,        32'h0000_0000);
        check({tag, ".valid"}, 32'(ifid_valid), 32'd0);
        check({tag, ".state"}, 32'(fsm_state),  32'(IF_IDLE));
    endtask

    // ---------------- driver ----------------
    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        PC_Write   = v.pc_write;
        IFID_Write = v.ifid_write;
        IFID_Clear = v.ifid_clear;
        PC_Br      = v.pc_br;
        br_target  = v.target;
        imem_ready = v.ready;
        #1;
        check({tag, ".req"},  32'(imem_req), 32'(v.exp_req));
        check({tag, ".addr"}, imem_addr,     v.exp_addr);
        @(posedge clk);
        #1;
        check({tag, ".inst"},  ifid_inst,       v.exp_inst);
        check({tag, ".pc4"},   ifid_pc4,        v.exp_pc4);
        check({tag, ".valid"}, 32'(ifid_valid), 32'(v.exp_valid));
    endtask

    vec_t vecs[17];
    vec_t drop_seq[5];

    // ---------------- test ----------------
    initial begin
        PC_Write = 1'b1; IFID_Write = 1'b1; IFID_Clear = 1'b0; PC_Br = 1'b0;
        br_target = 32'd0; imem_ready = 1'b1;

        //          pw iw cl br target         rdy req addr           inst           pc4            v
        vecs[0]  = mk(1, 1, 0, 0, 32'h0,        1, 0, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 0);
        vecs[1]  = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3000, 32'h0000_3000, 32'h0000_3004, 1);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3004, 32'h0000_3004, 32'h0000_3008, 1);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 1);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 1);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,        1, 0, 32'h0000_3008, 32'h0000_3008, 32'h0000_300C, 1);
        vecs[6]  = mk(1, 1, 0, 1, 32'h3040,     1, 1, 32'h0000_300C, 32'h0000_0000, 32'h0000_300C, 0);
        vecs[7]  = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_3044, 1);
        vecs[8]  = mk(1, 1, 1, 0, 32'h0,        1, 1, 32'h0000_3044, 32'h0000_0000, 32'h0000_3044, 0);
        vecs[9]  = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3048, 32'h0000_3048, 32'h0000_304C, 1);
        vecs[10] = mk(1, 1, 0, 1, 32'hFFFFFFFC, 1, 1, 32'h0000_304C, 32'h0000_0000, 32'h0000_304C, 0);
        vecs[11] = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1);
        vecs[12] = mk(1, 1, 0, 1, 32'h3043,     1, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0);
        vecs[13] = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3040, 32'h0000_3040, 32'h0000_3044, 1);
        vecs[14] = mk(1, 0, 0, 0, 32'h0,        0, 1, 32'h0000_3044, 32'h0000_3040, 32'h0000_3044, 1);
        vecs[15] = mk(1, 1, 0, 0, 32'h0,        0, 1, 32'h0000_3044, 32'h0000_0000, 32'h0000_3044, 0);
        vecs[16] = mk(1, 1, 0, 0, 32'h0,        1, 1, 32'h0000_3044, 32'h0000_3044, 32'h0000_3048, 1);

        // Redirect while the 3048 request waits; a second redirect lands mid-wait.
        drop_seq[0] = mk(1, 1, 0, 1, 32'h3080, 0, 1, 32'h0000_3048, 32'h0000_0000, 32'h0000_3048, 0);
        drop_seq[1] = mk(1, 1, 0, 0, 32'h0,    0, 1, 32'h0000_3048, 32'h0000_0000, 32'h0000_3048, 0);
        drop_seq[2] = mk(1, 1, 0, 1, 32'h30C0, 0, 1, 32'h0000_3048, 32'h0000_0000, 32'h0000_3048, 0);
        drop_seq[3] = mk(1, 1, 0, 0, 32'h0,    1, 1, 32'h0000_3048, 32'h0000_0000, 32'h0000_3048, 0);
        drop_seq[4] = mk(1, 1, 0, 0, 32'h0,    1, 1, 32'h0000_30C0, 32'h0000_30C0, 32'h0000_30C4, 1);

        // Reset with ready high: nothing may be captured.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Main table: streaming, stall/skid, redirect, clear, wrap, alignment, wait states.
        for (int i = 0; i < 17; i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Drain of a stale request after redirect.
        for (int i = 0; i < 5; i++) begin
            apply_vec(drop_seq[i], $sformatf("drop%0d", i));
            if (i == 0 || i == 2) check($sformatf("drop%0d.state", i), 32'(fsm_state), 32'(IF_DROP));
            if (i == 3)           check("drop3.state", 32'(fsm_state), 32'(IF_FETCH));
        end

        // Reset asserted while a request is waiting.
        apply_vec(mk(1, 1, 0, 0, 32'h0, 0, 1, 32'h0000_30C4, 32'h0000_0000, 32'h0000_30C4, 0), "wait");
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_ready_pulse");
        @(negedge clk);
        imem_ready = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply_vec(mk(1, 1, 0, 0, 32'h0, 1, 0, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 0), "rel0");
        apply_vec(mk(1, 1, 0, 0, 32'h0, 1, 1, 32'h0000_3000, 32'h0000_3000, 32'h0000_3004, 1), "rel1");
        apply_vec(mk(1, 1, 0, 0, 32'h0, 1, 1, 32'h0000_3004, 32'h0000_3004, 32'h0000_3008, 1), "rel2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
